// File: rtl/cond_flag_bank.sv
// Banked condition-flag store with a registered condition-code evaluator.
// Optional macro COND_BYPASS_EN: a same-cycle write to the evaluated bank forwards alu_flags.
package cond_flag_bank_pkg;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_CS = 4'h2,
    CC_CC = 4'h3,
    CC_MI = 4'h4,
    CC_PL = 4'h5,
    CC_VS = 4'h6,
    CC_VC = 4'h7,
    CC_HI = 4'h8,
    CC_LS = 4'h9,
    CC_GE = 4'hA,
    CC_LT = 4'hB,
    CC_GT = 4'hC,
    CC_LE = 4'hD,
    CC_AL = 4'hE,
    CC_NV = 4'hF
  } cond_e;

  // Flag nibble layout is {N,Z,C,V}; higher flag bits never take part in a decode.
  function automatic logic cond_eval(input logic [3:0] nzcv, input logic [3:0] code);
    logic n, z, c, v;
    logic result;
    {n, z, c, v} = nzcv;
    result = 1'b0;
    unique case (cond_e'(code))
      CC_EQ: result = z;
      CC_NE: result = !z;
      CC_CS: result = c;
      CC_CC: result = !c;
      CC_MI: result = n;
      CC_PL: result = !n;
      CC_VS: result = v;
      CC_VC: result = !v;
      CC_HI: result = c && !z;
      CC_LS: result = !c || z;
      CC_GE: result = (n == v);
      CC_LT: result = (n != v);
      CC_GT: result = !z && (n == v);
      CC_LE: result = z || (n != v);
      CC_AL: result = 1'b1;
      CC_NV: result = 1'b0;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

module cond_flag_bank
  import cond_flag_bank_pkg::*;
#(
  parameter int FLAG_W  = 4,
  parameter int BANK_AW = 2,
  localparam int NUM_BANKS = 1 << BANK_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLAG_W-1:0]    alu_flags,
  input  logic                 set_cond,
  input  logic [BANK_AW-1:0]   wr_bank,
  input  logic                 eval_valid,
  input  logic [BANK_AW-1:0]   rd_bank,
  input  logic [3:0]           cond_code,
  output logic                 cond_valid,
  output logic                 cond_pass,
  output logic                 cond_stale,
  output logic [FLAG_W-1:0]    flags_out,
  output logic [NUM_BANKS-1:0] bank_valid
);

  logic [FLAG_W-1:0] banks [NUM_BANKS];

  logic [FLAG_W-1:0] eval_src;
  logic              eval_stale;

  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    eval_src   = banks[rd_bank];
    eval_stale = !bank_valid[rd_bank];
`ifdef COND_BYPASS_EN
    if (set_cond && (wr_bank == rd_bank)) begin
      eval_src   = alu_flags;
      eval_stale = 1'b0;
    end
`endif
  end

  // NOTE: the bank array is reset explicitly because a stale bank must read back
  // as zero; a plain storage RAM would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        banks[b] <= '0;
      end
      bank_valid <= '0;
    end else if (set_cond) begin
      // NOTE: non-blocking assignments keep the eval path reading the pre-edge bank
      // contents regardless of statement order.
      banks[wr_bank]      <= alu_flags;
      bank_valid[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cond_valid <= 1'b0;
      cond_pass  <= 1'b0;
      cond_stale <= 1'b0;
      flags_out  <= '0;
    end else begin
      cond_valid <= eval_valid;
      if (eval_valid) begin
        cond_pass  <= cond_eval(eval_src[3:0], cond_code);
        cond_stale <= eval_stale;
        flags_out  <= eval_src;
      end
    end
  end

endmodule

// File: tb/tb_cond_flag_bank.sv
// Directed self-checking bench for cond_flag_bank (default parameters, either bypass build).
module tb_cond_flag_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_flags;
  logic       set_cond;
  logic [1:0] wr_bank;
  logic       eval_valid;
  logic [1:0] rd_bank;
  logic [3:0] cond_code;
  logic       cond_valid;
  logic       cond_pass;
  logic       cond_stale;
  logic [3:0] flags_out;
  logic [3:0] bank_valid;

  int tests_run = 0;
  int tests_failed = 0;

  cond_flag_bank dut (
    .clk        (clk),
    .rst        (rst),
    .alu_flags  (alu_flags),
    .set_cond   (set_cond),
    .wr_bank    (wr_bank),
    .eval_valid (eval_valid),
    .rd_bank    (rd_bank),
    .cond_code  (cond_code),
    .cond_valid (cond_valid),
    .cond_pass  (cond_pass),
    .cond_stale (cond_stale),
    .flags_out  (flags_out),
    .bank_valid (bank_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive_eval(input logic en, input logic [1:0] bank, input logic [3:0] code);
    eval_valid = en;
    rd_bank    = bank;
    cond_code  = code;
  endtask

  task automatic drive_write(input logic en, input logic [1:0] bank, input logic [3:0] flags);
    set_cond  = en;
    wr_bank   = bank;
    alu_flags = flags;
  endtask

  initial begin
    rst = 1'b1;
    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b0, 2'd0, 4'h0);

    // Reset held two cycles
    tick();
    tick();
    check("rst_cond_valid", cond_valid, 1'b0);
    check("rst_cond_pass", cond_pass, 1'b0);
    check("rst_cond_stale", cond_stale, 1'b0);
    check("rst_flags_out", flags_out, 4'h0);
    check("rst_bank_valid", bank_valid, 4'b0000);

    // AL on never-written bank0
    rst = 1'b0;
    drive_eval(1'b1, 2'd0, 4'hE);
    tick();
    check("al_valid", cond_valid, 1'b1);
    check("al_pass", cond_pass, 1'b1);
    check("al_stale", cond_stale, 1'b1);
    check("al_flags", flags_out, 4'h0);

    // Write bank1 = Z only; no eval this cycle so outputs hold
    drive_eval(1'b0, 2'd0, 4'h0);
    drive_write(1'b1, 2'd1, 4'b0100);
    tick();
    check("idle_valid", cond_valid, 1'b0);
    check("idle_pass_hold", cond_pass, 1'b1);
    check("idle_stale_hold", cond_stale, 1'b1);
    check("wr1_bank_valid", bank_valid, 4'b0010);

    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b1, 2'd1, 4'h0);
    tick();
    check("b1_eq_pass", cond_pass, 1'b1);
    check("b1_eq_stale", cond_stale, 1'b0);
    check("b1_eq_flags", flags_out, 4'b0100);
    drive_eval(1'b1, 2'd1, 4'h1);
    tick();
    check("b1_ne_valid", cond_valid, 1'b1);
    check("b1_ne_pass", cond_pass, 1'b0);
    drive_eval(1'b1, 2'd1, 4'h9);
    tick();
    check("b1_ls_pass", cond_pass, 1'b1);

    // Signed compares on bank2 = N,V set
    drive_eval(1'b0, 2'd0, 4'h0);
    drive_write(1'b1, 2'd2, 4'b1001);
    tick();
    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b1, 2'd2, 4'hA);
    tick();
    check("b2_ge_pass", cond_pass, 1'b1);
    drive_eval(1'b1, 2'd2, 4'hB);
    tick();
    check("b2_lt_pass", cond_pass, 1'b0);
    drive_eval(1'b1, 2'd2, 4'hC);
    tick();
    check("b2_gt_pass", cond_pass, 1'b1);
    drive_eval(1'b1, 2'd2, 4'hD);
    tick();
    check("b2_le_pass", cond_pass, 1'b0);
    drive_eval(1'b1, 2'd2, 4'hF);
    tick();
    check("b2_nv_pass", cond_pass, 1'b0);
    check("b2_flags", flags_out, 4'b1001);

    // Same-cycle same-bank hazard on bank3
    drive_eval(1'b0, 2'd0, 4'h0);
    drive_write(1'b1, 2'd3, 4'b0000);
    tick();
    drive_write(1'b1, 2'd3, 4'b0100);
    drive_eval(1'b1, 2'd3, 4'h0);
    tick();
`ifdef COND_BYPASS_EN
    check("hz_pass", cond_pass, 1'b1);
    check("hz_flags", flags_out, 4'b0100);
`else
    check("hz_pass", cond_pass, 1'b0);
    check("hz_flags", flags_out, 4'b0000);
`endif
    check("hz_stale", cond_stale, 1'b0);
    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b1, 2'd3, 4'h0);
    tick();
    check("hz_after_pass", cond_pass, 1'b1);
    check("pre_rst_bank_valid", bank_valid, 4'b1110);

    // Reset mid-stream overrides eval and write
    rst = 1'b1;
    drive_write(1'b1, 2'd2, 4'b1111);
    drive_eval(1'b1, 2'd2, 4'hE);
    tick();
    check("mrst_valid", cond_valid, 1'b0);
    check("mrst_pass", cond_pass, 1'b0);
    check("mrst_flags", flags_out, 4'h0);
    check("mrst_bank_valid", bank_valid, 4'b0000);
    rst = 1'b0;
    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b1, 2'd2, 4'hB);
    tick();
    check("mrst_b2_lt_pass", cond_pass, 1'b0);
    check("mrst_b2_flags", flags_out, 4'h0);
    check("mrst_b2_stale", cond_stale, 1'b1);

    // Bank isolation
    drive_eval(1'b0, 2'd0, 4'h0);
    drive_write(1'b1, 2'd0, 4'b0010);
    tick();
    drive_write(1'b1, 2'd1, 4'b0000);
    tick();
    check("iso_bank_valid", bank_valid, 4'b0011);
    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b1, 2'd0, 4'h2);
    tick();
    check("iso_b0_cs_pass", cond_pass, 1'b1);
    drive_eval(1'b1, 2'd1, 4'h2);
    tick();
    check("iso_b1_cs_pass", cond_pass, 1'b0);
    check("iso_b1_stale", cond_stale, 1'b0);

    // Write and eval on different banks in the same cycle are independent
    drive_write(1'b1, 2'd0, 4'b1000);
    drive_eval(1'b1, 2'd1, 4'h4);
    tick();
    check("indep_b1_mi_pass", cond_pass, 1'b0);
    drive_write(1'b0, 2'd0, 4'h0);
    drive_eval(1'b1, 2'd0, 4'h4);
    tick();
    check("indep_b0_mi_pass", cond_pass, 1'b1);
    check("indep_b0_flags", flags_out, 4'b1000);
    drive_eval(1'b1, 2'd3, 4'hE);
    tick();
    check("b3_stale", cond_stale, 1'b1);

    drive_eval(1'b0, 2'd0, 4'h0);
    tick();
    check("final_idle_valid", cond_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
